// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if
// Bundles every signal of spi_master_arbiter except clk/rst: the requester
// side (req/last/tx_data in, tx_ready/rx_data/rx_valid/grant/cs_n/busy/err
// out), the SPI_MASTER side (m_start/m_tx out, m_ss/m_rx in) and a debug view
// of the arbiter FSM state and round-robin pointer.
//
// Handshake semantics (the only place they are written down):
//   - A requester raises req[i] and keeps it high for its whole transaction,
//     presenting its current byte on tx_data[i*DWIDTH +: DWIDTH] together with
//     last[i]. A one-cycle tx_ready[i] pulse means that byte and flag were
//     consumed; the next byte must be on the bus before the next load.
//   - rx_valid[i] is a one-cycle pulse qualifying the shared rx_data for
//     requester i. There is no back-pressure on rx.
//   - err[i] is a one-cycle pulse when the SPI master never lowered ss.
//
// Modports:
//   master - the arbiter itself (owns grant/chip selects and drives the
//            SPI_MASTER start/tx inputs).
//   slave  - the environment: requesters plus the SPI_MASTER instance.
interface spi_master_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        last;
  logic [NREQ*DWIDTH-1:0] tx_data;
  logic [NREQ-1:0]        tx_ready;
  logic [DWIDTH-1:0]      rx_data;
  logic [NREQ-1:0]        rx_valid;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        cs_n;
  logic                   busy;
  logic [NREQ-1:0]        err;
  logic                   m_start;
  logic [DWIDTH-1:0]      m_tx;
  logic                   m_ss;
  logic [DWIDTH-1:0]      m_rx;
  logic [2:0]             dbg_state;
  logic [PW-1:0]          dbg_ptr;

  modport master (
    input  req, last, tx_data, m_ss, m_rx,
    output tx_ready, rx_data, rx_valid, grant, cs_n, busy, err,
           m_start, m_tx, dbg_state, dbg_ptr
  );

  modport slave (
    output req, last, tx_data, m_ss, m_rx,
    input  tx_ready, rx_data, rx_valid, grant, cs_n, busy, err,
           m_start, m_tx, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
// Shares one SPI_MASTER among NREQ requesters. A round-robin pick selects the
// owner, its active-low chip select is held for every byte of its
// transaction, each byte is pushed through the master's start/tx inputs and
// the byte received on m_rx is routed back with a one-hot rx_valid.
//
// Ports:
//   clk  - system clock (same clock as SPI_MASTER)
//   rst  - synchronous, active-low reset
//   bus  - spi_master_arbiter_if.master: requester handshake, SPI_MASTER
//          control/data, debug state (dbg_state) and pointer (dbg_ptr)
//
// Parameters NREQ and DWIDTH must match those of the connected interface.
module spi_master_arbiter #(
  parameter int NREQ          = 4,
  parameter int DWIDTH        = 8,
  parameter int CS_GAP        = 2,
  parameter int START_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_arbiter_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_XFER    = 3'd3,
    S_RELEASE = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     g;
  logic [PW-1:0]     sel;
  logic              sel_valid;
  logic [PW:0]       sum;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic              last_r;
  logic              start_timeout;

  logic [NREQ-1:0]   grant_r;
  logic [NREQ-1:0]   cs_n_r;
  logic [NREQ-1:0]   tx_ready_r;
  logic [NREQ-1:0]   rx_valid_r;
  logic [NREQ-1:0]   err_r;
  logic              m_start_r;
  logic [DWIDTH-1:0] m_tx_r;
  logic [DWIDTH-1:0] rx_data_r;

  // Round-robin pick: first requester at or after ptr, wrapping around.
  always_comb begin
    sel       = ptr;
    sel_valid = 1'b0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!sel_valid && bus.req[sum[PW-1:0]]) begin
        sel       = sum[PW-1:0];
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    start_timeout = 1'b0;
    case (state)
      S_IDLE:    if (sel_valid) state_nx = S_LOAD;
      S_LOAD:    state_nx = S_START;
      S_START: begin
        // A low ss wins over a timeout expiring in the same cycle.
        if (!bus.m_ss) begin
          state_nx = S_XFER;
        end else if (timer == TW'(START_TIMEOUT - 1)) begin
          start_timeout = 1'b1;
          state_nx      = S_RELEASE;
        end
      end
      S_XFER: begin
        if (bus.m_ss) begin
          // A requester that drops req without last aborts quietly.
          if (last_r || !bus.req[g]) state_nx = S_RELEASE;
          else                       state_nx = S_LOAD;
        end
      end
      S_RELEASE: state_nx = S_GAP;
      S_GAP:     if (gap_cnt == GW'(CS_GAP - 1)) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr        <= '0;
      g          <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      last_r     <= 1'b0;
      grant_r    <= '0;
      cs_n_r     <= '1;
      tx_ready_r <= '0;
      rx_valid_r <= '0;
      err_r      <= '0;
      m_start_r  <= 1'b0;
      m_tx_r     <= '0;
      rx_data_r  <= '0;
    end else begin
      tx_ready_r <= '0;
      rx_valid_r <= '0;
      err_r      <= '0;
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            g       <= sel;
            grant_r <= NREQ'(1) << sel;
            cs_n_r  <= ~(NREQ'(1) << sel);
          end
        end
        S_LOAD: begin
          m_tx_r     <= bus.tx_data[g*DWIDTH +: DWIDTH];
          last_r     <= bus.last[g];
          tx_ready_r <= grant_r;
          m_start_r  <= 1'b1;
          timer      <= '0;
        end
        S_START: begin
          if (!bus.m_ss) begin
            m_start_r <= 1'b0;
          end else if (start_timeout) begin
            m_start_r <= 1'b0;
            err_r     <= grant_r;
            timer     <= TW'(START_TIMEOUT);
          end else if (timer != TW'(START_TIMEOUT)) begin
            timer <= timer + 1'b1;
          end
        end
        S_XFER: begin
          if (bus.m_ss) begin
            rx_data_r  <= bus.m_rx;
            rx_valid_r <= grant_r;
          end
        end
        S_RELEASE: begin
          cs_n_r  <= '1;
          grant_r <= '0;
          ptr     <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
          gap_cnt <= '0;
        end
        S_GAP:   gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.cs_n      = cs_n_r;
  assign bus.tx_ready  = tx_ready_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.err       = err_r;
  assign bus.m_start   = m_start_r;
  assign bus.m_tx      = m_tx_r;
  assign bus.rx_data   = rx_data_r;
  assign bus.busy      = (state != S_IDLE);
  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr;
endmodule
